beat_sequencer: RTL and testbench
=================================

// Module: beat_sequencer
// PURPOSE
//  Parametrised player controller: generates the beat index (ibeat) that drives music ROM,
//  LED and note generation. Adds play/pause/stop, one-shot vs loop mode, and runtime speed
//  steps from one internal prescaler. This replaces a fixed divided clock with a clk-domain tick.
//  Sits between the debounced/one-pulsed buttons and the music/LED/note blocks.
// PARAMETERS
//  LEN          64       beats per song; ibeat runs 0..LEN-1
//  BEAT_W       12       ibeat width; must be >= $clog2(LEN)
//  BASE_PERIOD  2**20    clk cycles per beat at the fastest speed level
//  NUM_SPEEDS   5        speed levels 0 (slowest) .. NUM_SPEEDS-1 (fastest)
//  DEF_SPEED    2        speed level after reset (2**22 cycles/beat with defaults)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous, active-high reset
//  play         in   1        1-cycle pulse: toggle play/pause (already debounced + one-pulsed)
//  stop         in   1        1-cycle pulse: stop and rewind to beat 0
//  speedup      in   1        1-cycle pulse: speed level +1
//  speeddown    in   1        1-cycle pulse: speed level -1
//  loop_en      in   1        level: 1 = wrap LEN-1 -> 0, 0 = halt in DONE after last beat
//  ibeat        out  BEAT_W   current beat index
//  beat_tick    out  1        1-cycle pulse on every ibeat advance (LED shift enable)
//  playing      out  1        1 while state == PLAY
//  done         out  1        1 while state == DONE
//  speed_level  out  3        current speed level
// BEHAVIOUR
//  Reset: state=IDLE, ibeat=0, cnt=0, beat_tick=0, playing=0, done=0, speed_level=DEF_SPEED.
//  period(level) = BASE_PERIOD << (NUM_SPEEDS-1-level); cnt width PW = $clog2(period(0)).
//  States: IDLE (stopped, beat 0), PLAY, PAUSE, DONE.
//   IDLE  --play--> PLAY;  PLAY --play--> PAUSE;  PAUSE --play--> PLAY (resumes, cnt kept)
//   PLAY  --last beat, loop_en=0--> DONE;  DONE --play--> PLAY from ibeat=0, cnt=0
//   any   --stop--> IDLE, ibeat=0, cnt=0 (stop wins over play in the same cycle)
//  Prescaler: counts only in PLAY. If cnt >= period(level)-1: cnt<=0, beat_tick<=1 next
//   cycle-registered with ibeat update; else cnt<=cnt+1. Frozen in PAUSE/IDLE/DONE.
//  Advance: on tick, ibeat<=ibeat+1; at ibeat==LEN-1: loop_en=1 -> ibeat<=0, stay PLAY;
//   loop_en=0 -> ibeat stays LEN-1, state<=DONE, beat_tick still pulses for that boundary.
//  Latency: play pulse at cycle t -> playing=1 at t+1; first tick period(level) cycles later.
//  Speed: speedup/speeddown saturate at NUM_SPEEDS-1 / 0; both in same cycle -> no change.
//   Accepted in every state. Change takes effect immediately; cnt not cleared; if cnt already
//   >= new period-1 the tick fires on the next counting cycle (no wrap-around of cnt).
//  Simultaneous: play+speed change both apply; tick + stop in same cycle -> stop wins,
//   no beat_tick. play in DONE with loop_en toggled meanwhile: loop_en sampled only at LEN-1.
//  Reset mid-play: all outputs return to reset values asynchronously; no pending tick survives.
//  All outputs registered; no combinational path input -> output.
// STRUCTURE
//  Include player_defs.vh: state encodings (ST_IDLE/ST_PLAY/ST_PAUSE/ST_DONE) and speed-level
//   width localparam, shared with led_controller and the 7-segment speed display.
//  One sub-module: beat_prescaler (cnt, period select by speed_level, en, clr -> tick).
//  beat_sequencer holds FSM, ibeat counter and speed-level register.
// TESTING  (bench params: LEN=8, BASE_PERIOD=4, NUM_SPEEDS=3, DEF_SPEED=1 -> period 8)
//  1 rst, play pulse -> playing=1 next cycle; beat_tick every 8 cycles; ibeat 0,1..7,0 with loop_en=1.
//  2 loop_en=0, play to end -> at beat 7 tick: done=1, playing=0, ibeat holds 7; play -> ibeat 0, PLAY.
//  3 play, wait 3 cycles, play (pause) 20 cycles, play -> next tick exactly 5 counting cycles later.
//  4 speedup x3 -> speed_level saturates 2, period 4; speeddown x3 -> 0, period 16; both same cycle -> unchanged.
//  5 at cnt=6 (level1) speedup -> tick on next counting cycle; stop coincident with tick -> ibeat=0, no tick.
//  6 assert rst mid-PLAY at ibeat=5 -> ibeat=0, playing=0, speed_level=1 immediately (async).

Source files
------------

// File: rtl/beat_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beat_sequencer_pkg
//  Description : Shared definitions for the music player controller.
//                Holds the player state encoding, the speed-level width
//                used by the sequencer and the speed display, and the
//                helper that maps a speed level to its beat period.
//  Revision    : 1.0  initial release
// ============================================================================
package beat_sequencer_pkg;

    // Speed level width; also used by the 7-segment speed display.
    localparam int c_SPEED_W = 3;

    // Player states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // stopped, rewound to beat 0
        ST_PLAY  = 2'd1,   // prescaler running, beats advancing
        ST_PAUSE = 2'd2,   // frozen, position and prescaler kept
        ST_DONE  = 2'd3    // one-shot song finished, parked on last beat
    } player_state_t;

    // Clock cycles per beat at a given speed level. Level 0 is the slowest;
    // each step up halves the period down to base at the fastest level.
    function automatic logic [63:0] beat_period(
        input int unsigned base,
        input int unsigned num_speeds,
        input int unsigned level
    );
        beat_period = 64'(base) << (num_speeds - 1 - level);
    endfunction

endpackage : beat_sequencer_pkg
`default_nettype wire

// File: rtl/beat_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : beat_prescaler
//  Description : Beat-rate prescaler. Counts clk cycles while enabled and
//                flags the cycle on which the current beat period expires.
//                The period is selected at run time from the speed level.
//  Ports       : clk   - system clock
//                rst   - asynchronous active-high reset
//                en    - count this cycle (player is playing)
//                clr   - return the count to zero (has priority over en)
//                level - current speed level, selects the period
//                tick  - combinational: this counting cycle ends the beat
//  Revision    : 1.0  initial release
// ============================================================================
module beat_prescaler
    import beat_sequencer_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 32'd1048576,
    parameter int unsigned NUM_SPEEDS  = 5
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [c_SPEED_W-1:0] level,
    output logic                 tick
);

    // The slowest period sets the counter width.
    localparam logic [63:0] c_PERIOD_MAX = beat_period(BASE_PERIOD, NUM_SPEEDS, 0);
    localparam int          c_PW         = (c_PERIOD_MAX > 64'd1) ? $clog2(c_PERIOD_MAX) : 1;

    logic [c_PW-1:0] r_cnt;
    logic [63:0]     w_period;

    // Comparing with >= rather than == matters after a speed-up: the count
    // may already be past the new, shorter period, and it must expire on the
    // next counting cycle instead of running on until it wraps.
    always_comb begin
        w_period = beat_period(BASE_PERIOD, NUM_SPEEDS, 32'(level));
        tick     = en && (64'(r_cnt) >= (w_period - 64'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_PW'(1);
            end
        end
    end

endmodule : beat_prescaler
`default_nettype wire

// File: rtl/beat_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : beat_sequencer
//  Description : Player controller producing the beat index for the music
//                ROM, LED and note blocks. Play/pause toggle, stop/rewind,
//                one-shot or loop playback and run-time speed levels, all
//                timed by a clk-domain prescaler instead of a divided clock.
//  Ports       : clk          - system clock
//                rst          - asynchronous active-high reset
//                play         - pulse: toggle play/pause (restart from DONE)
//                stop         - pulse: stop and rewind to beat 0
//                speedup      - pulse: speed level +1 (saturating)
//                speeddown    - pulse: speed level -1 (saturating)
//                loop_en      - level: wrap after last beat instead of DONE
//                ibeat        - current beat index 0..LEN-1
//                beat_tick    - pulse on every ibeat advance
//                playing      - high while playing
//                done         - high while parked at the end of the song
//                speed_level  - current speed level
//  Revision    : 1.0  initial release
// ============================================================================
module beat_sequencer
    import beat_sequencer_pkg::*;
#(
    parameter int unsigned LEN         = 64,
    parameter int unsigned BEAT_W      = 12,
    parameter int unsigned BASE_PERIOD = 32'd1048576,
    parameter int unsigned NUM_SPEEDS  = 5,
    parameter int unsigned DEF_SPEED   = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 play,
    input  logic                 stop,
    input  logic                 speedup,
    input  logic                 speeddown,
    input  logic                 loop_en,
    output logic [BEAT_W-1:0]    ibeat,
    output logic                 beat_tick,
    output logic                 playing,
    output logic                 done,
    output logic [c_SPEED_W-1:0] speed_level
);

    localparam logic [BEAT_W-1:0]    c_LAST_BEAT = BEAT_W'(LEN - 1);
    localparam logic [c_SPEED_W-1:0] c_MAX_LVL   = c_SPEED_W'(NUM_SPEEDS - 1);
    localparam logic [c_SPEED_W-1:0] c_DEF_LVL   = c_SPEED_W'(DEF_SPEED);

    player_state_t          r_state;
    player_state_t          w_state_next;
    logic [BEAT_W-1:0]      r_ibeat;
    logic [BEAT_W-1:0]      w_ibeat_next;
    logic                   r_beat_tick;
    logic                   w_tick_next;
    logic                   r_playing;
    logic                   r_done;
    logic [c_SPEED_W-1:0]   r_level;
    logic [c_SPEED_W-1:0]   w_level_next;
    logic                   w_pre_en;
    logic                   w_pre_clr;
    logic                   w_pre_tick;

    // Restarting from DONE clears the count as well; it is already zero
    // there, but making it explicit keeps the restart independent of how
    // DONE was entered.
    assign w_pre_en  = (r_state == ST_PLAY);
    assign w_pre_clr = stop || ((r_state == ST_DONE) && play);

    beat_prescaler #(
        .BASE_PERIOD (BASE_PERIOD),
        .NUM_SPEEDS  (NUM_SPEEDS)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (w_pre_en),
        .clr   (w_pre_clr),
        .level (r_level),
        .tick  (w_pre_tick)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_next = r_state;
        w_ibeat_next = r_ibeat;
        w_tick_next  = 1'b0;
        w_level_next = r_level;

        // Speed steps apply in every state; a simultaneous up and down cancel.
        if (speedup && !speeddown && (r_level != c_MAX_LVL)) begin
            w_level_next = r_level + c_SPEED_W'(1);
        end else if (speeddown && !speedup && (r_level != '0)) begin
            w_level_next = r_level - c_SPEED_W'(1);
        end

        if (stop) begin
            // Stop overrides everything, including a beat that would have
            // advanced this cycle.
            w_state_next = ST_IDLE;
            w_ibeat_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (play) begin
                        w_state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (play) begin
                        w_state_next = ST_PAUSE;
                    end
                    if (w_pre_tick) begin
                        w_tick_next = 1'b1;
                        if (r_ibeat == c_LAST_BEAT) begin
                            if (loop_en) begin
                                w_ibeat_next = '0;
                            end else begin
                                // Reaching the end of a one-shot song takes
                                // precedence over a coincident pause.
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            w_ibeat_next = r_ibeat + BEAT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (play) begin
                        w_state_next = ST_PLAY;
                    end
                end
                ST_DONE: begin
                    if (play) begin
                        w_state_next = ST_PLAY;
                        w_ibeat_next = '0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_ibeat_next = '0;
                end
            endcase
        end
    end

    // State and output registers; the status flags are decoded from the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ibeat     <= '0;
            r_beat_tick <= 1'b0;
            r_playing   <= 1'b0;
            r_done      <= 1'b0;
            r_level     <= c_DEF_LVL;
        end else begin
            r_state     <= w_state_next;
            r_ibeat     <= w_ibeat_next;
            r_beat_tick <= w_tick_next;
            r_playing   <= (w_state_next == ST_PLAY);
            r_done      <= (w_state_next == ST_DONE);
            r_level     <= w_level_next;
        end
    end

    assign ibeat       = r_ibeat;
    assign beat_tick   = r_beat_tick;
    assign playing     = r_playing;
    assign done        = r_done;
    assign speed_level = r_level;

endmodule : beat_sequencer
`default_nettype wire

// File: tb/tb_beat_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beat_sequencer
//  Description : Self-checking bench for beat_sequencer with a small song
//                (8 beats, periods 16/8/4 cycles). A behavioural player
//                model tracks mode, position, elapsed cycles in the current
//                beat and speed level, and every clock cycle the DUT outputs
//                are compared with it. A vector table covers speed
//                saturation, hand-written sequences cover the multi-cycle
//                corner cases, and a random phase exercises everything.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_beat_sequencer;

    localparam int LEN_P  = 8;
    localparam int BW_P   = 4;
    localparam int BASE_P = 4;
    localparam int NSP_P  = 3;
    localparam int DEF_P  = 1;

    localparam int M_STOP  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_FIN   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            play = 1'b0;
    logic            stop = 1'b0;
    logic            speedup = 1'b0;
    logic            speeddown = 1'b0;
    logic            loop_en = 1'b1;
    logic [BW_P-1:0] ibeat;
    logic            beat_tick;
    logic            playing;
    logic            done;
    logic [2:0]      speed_level;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_mode;
    int m_pos;
    int m_el;     // counting cycles already spent in the current beat
    int m_lvl;
    int m_tick;

    typedef struct {
        bit play;
        bit stop;
        bit up;
        bit down;
        int e_playing;
        int e_level;
        int e_ibeat;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    beat_sequencer #(
        .LEN         (LEN_P),
        .BEAT_W      (BW_P),
        .BASE_PERIOD (BASE_P),
        .NUM_SPEEDS  (NSP_P),
        .DEF_SPEED   (DEF_P)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .play        (play),
        .stop        (stop),
        .speedup     (speedup),
        .speeddown   (speeddown),
        .loop_en     (loop_en),
        .ibeat       (ibeat),
        .beat_tick   (beat_tick),
        .playing     (playing),
        .done        (done),
        .speed_level (speed_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int lvl);
        return BASE_P * (1 << (NSP_P - 1 - lvl));
    endfunction

    task automatic model_reset();
        m_mode = M_STOP;
        m_pos  = 0;
        m_el   = 0;
        m_lvl  = DEF_P;
        m_tick = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int  nmode = m_mode;
        int  npos  = m_pos;
        int  nel   = m_el;
        int  nlvl  = m_lvl;
        bit  t     = 1'b0;
        if (m_mode == M_RUN) begin
            if (m_el + 1 >= period_of(m_lvl)) begin
                t   = 1'b1;
                nel = 0;
            end else begin
                nel = m_el + 1;
            end
        end
        if (stop) begin
            nmode = M_STOP;
            npos  = 0;
            nel   = 0;
            t     = 1'b0;
        end else begin
            case (m_mode)
                M_STOP:  if (play) nmode = M_RUN;
                M_PAUSE: if (play) nmode = M_RUN;
                M_FIN: begin
                    if (play) begin
                        nmode = M_RUN;
                        npos  = 0;
                        nel   = 0;
                    end
                end
                default: begin
                    if (play) nmode = M_PAUSE;
                    if (t) begin
                        if (m_pos == LEN_P - 1) begin
                            if (loop_en) npos = 0;
                            else         nmode = M_FIN;
                        end else begin
                            npos = m_pos + 1;
                        end
                    end
                end
            endcase
        end
        if (speedup && !speeddown && m_lvl < NSP_P - 1) nlvl = m_lvl + 1;
        if (speeddown && !speedup && m_lvl > 0)         nlvl = m_lvl - 1;
        m_mode = nmode;
        m_pos  = npos;
        m_el   = nel;
        m_lvl  = nlvl;
        m_tick = int'(t);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ibeat"},   int'(ibeat),       m_pos);
        chk({tag, "_tick"},    int'(beat_tick),   m_tick);
        chk({tag, "_playing"}, int'(playing),     int'(m_mode == M_RUN));
        chk({tag, "_done"},    int'(done),        int'(m_mode == M_FIN));
        chk({tag, "_level"},   int'(speed_level), m_lvl);
    endtask

    // One clock: model follows the driven inputs, outputs are checked 1 time
    // unit after the edge, then the one-cycle pulses are released.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
        play      = 1'b0;
        stop      = 1'b0;
        speedup   = 1'b0;
        speeddown = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_model("reset");
        rst = 1'b0;
    endtask

    initial begin
        // Speed saturation table, starting from level 1 after reset.
        vecs[0] = '{play: 0, stop: 0, up: 1, down: 0, e_playing: 0, e_level: 2, e_ibeat: 0};
        vecs[1] = '{play: 0, stop: 0, up: 1, down: 0, e_playing: 0, e_level: 2, e_ibeat: 0};
        vecs[2] = '{play: 0, stop: 0, up: 1, down: 0, e_playing: 0, e_level: 2, e_ibeat: 0};
        vecs[3] = '{play: 0, stop: 0, up: 0, down: 1, e_playing: 0, e_level: 1, e_ibeat: 0};
        vecs[4] = '{play: 0, stop: 0, up: 0, down: 1, e_playing: 0, e_level: 0, e_ibeat: 0};
        vecs[5] = '{play: 0, stop: 0, up: 0, down: 1, e_playing: 0, e_level: 0, e_ibeat: 0};
        vecs[6] = '{play: 0, stop: 0, up: 1, down: 1, e_playing: 0, e_level: 0, e_ibeat: 0};
        vecs[7] = '{play: 0, stop: 0, up: 1, down: 0, e_playing: 0, e_level: 1, e_ibeat: 0};
        vecs[8] = '{play: 1, stop: 0, up: 0, down: 0, e_playing: 1, e_level: 1, e_ibeat: 0};
        vecs[9] = '{play: 0, stop: 1, up: 1, down: 1, e_playing: 0, e_level: 1, e_ibeat: 0};

        #2;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            play      = vecs[i].play;
            stop      = vecs[i].stop;
            speedup   = vecs[i].up;
            speeddown = vecs[i].down;
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_playing", i), int'(playing),     vecs[i].e_playing);
            chk($sformatf("vec%0d_tbl_level", i),   int'(speed_level), vecs[i].e_level);
            chk($sformatf("vec%0d_tbl_ibeat", i),   int'(ibeat),       vecs[i].e_ibeat);
        end

        // Looping playback: tick every 8 cycles, ibeat wraps 7 -> 0.
        apply_reset();
        loop_en = 1'b1;
        play = 1'b1;
        cycle("t1_play");
        chk("t1_playing_next_cycle", int'(playing), 1);
        for (int i = 1; i <= 8; i++) begin
            cycle("t1_first");
            chk($sformatf("t1_first_tick_c%0d", i), int'(beat_tick), int'(i == 8));
        end
        chk("t1_ibeat_after_first", int'(ibeat), 1);
        repeat (7 * 8) cycle("t1_run");
        chk("t1_wrap_ibeat", int'(ibeat), 0);
        chk("t1_wrap_tick", int'(beat_tick), 1);

        // One-shot playback ends in DONE on beat 7, then restarts.
        apply_reset();
        loop_en = 1'b0;
        play = 1'b1;
        cycle("t2_play");
        repeat (64) cycle("t2_run");
        chk("t2_done", int'(done), 1);
        chk("t2_playing", int'(playing), 0);
        chk("t2_ibeat", int'(ibeat), 7);
        chk("t2_tick", int'(beat_tick), 1);
        repeat (20) cycle("t2_hold");
        chk("t2_hold_ibeat", int'(ibeat), 7);
        play = 1'b1;
        cycle("t2_restart");
        chk("t2_restart_ibeat", int'(ibeat), 0);
        chk("t2_restart_playing", int'(playing), 1);
        chk("t2_restart_done", int'(done), 0);
        loop_en = 1'b1;

        // Pause keeps the partial count: 3 counted, 5 remain after resume.
        apply_reset();
        play = 1'b1;
        cycle("t3_play");
        repeat (2) cycle("t3_count");
        play = 1'b1;
        cycle("t3_pause");
        chk("t3_paused", int'(playing), 0);
        repeat (20) cycle("t3_hold");
        play = 1'b1;
        cycle("t3_resume");
        chk("t3_resumed", int'(playing), 1);
        for (int i = 1; i <= 5; i++) begin
            cycle("t3_after");
            chk($sformatf("t3_tick_c%0d", i), int'(beat_tick), int'(i == 5));
        end

        // Speed-up with count already past the new period, then stop vs tick.
        apply_reset();
        play = 1'b1;
        cycle("t5_play");
        repeat (6) cycle("t5_count");
        speedup = 1'b1;
        cycle("t5_speedup");
        chk("t5_no_tick_yet", int'(beat_tick), 0);
        chk("t5_level", int'(speed_level), 2);
        cycle("t5_next");
        chk("t5_tick_next", int'(beat_tick), 1);
        chk("t5_ibeat1", int'(ibeat), 1);
        repeat (3) cycle("t5_count2");
        stop = 1'b1;
        cycle("t5_stop");
        chk("t5_stop_tick", int'(beat_tick), 0);
        chk("t5_stop_ibeat", int'(ibeat), 0);
        chk("t5_stop_playing", int'(playing), 0);

        // Asynchronous reset in the middle of play.
        apply_reset();
        play = 1'b1;
        cycle("t6_play");
        repeat (40) cycle("t6_run");
        chk("t6_ibeat5", int'(ibeat), 5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_async_ibeat", int'(ibeat), 0);
        chk("t6_async_playing", int'(playing), 0);
        chk("t6_async_level", int'(speed_level), DEF_P);
        chk("t6_async_tick", int'(beat_tick), 0);
        @(posedge clk);
        #1;
        check_model("t6_held");
        rst = 1'b0;

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            play      = ($urandom_range(0, 39) == 0);
            stop      = ($urandom_range(0, 299) == 0);
            speedup   = ($urandom_range(0, 24) == 0);
            speeddown = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) loop_en = ~loop_en;
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_beat_sequencer
`default_nettype wire
